timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  PicoBlaze-side controller/configurator for one timer instance. Decodes the
//  processor port bus into CTRL/LOAD/STATUS registers and drives the timer's
//  config inputs. Sequences the timer IDLE->ARMED->RUN and latches its rolloff
//  into a pending flag that drives the processor interrupt/ack handshake.
// PARAMETERS
//  BASE_ADDR  8'h10  port_id of CTRL; LOAD_L=+1, LOAD_H=+2, STATUS=+3
// PORTS
//  clk_in          in   1   system clock
//  rst             in   1   reset, synchronous, active-high
//  port_id         in   8   PicoBlaze port address
//  write_strobe    in   1   1-cycle write qualifier
//  out_port        in   8   write data
//  in_port         out  8   registered read data
//  interrupt       out  1   to PicoBlaze; held until interrupt_ack
//  interrupt_ack   in   1   1-cycle ack from PicoBlaze
//  prescaler_conf  out  3   to timer
//  timer_conf      out  16  to timer, reload value
//  tmr_en          out  1   to timer en
//  tmr_go          out  1   to timer go; held until go_clear
//  tmr_auto_load   out  1   to timer auto_load
//  tmr_int         in   1   timer rolloff pulse, 1 cycle
//  go_clear        in   1   timer accepted go, 1 cycle
// BEHAVIOUR
//  Write decode: wr = write_strobe & (port_id == addr). All regs update on clk_in.
//  CTRL (BASE+0) RW: [0] en, [1] go (write-only, reads 0), [2] auto_load,
//   [5:3] prescaler, [6] int_en, [7] rsvd (reads 0).
//  LOAD_L (+1) W: shadow byte only. LOAD_H (+2) W: timer_conf <= {out_port, shadow}
//   in one cycle. Writes while RUN are allowed; take effect at the timer's next load.
//  STATUS (+3) R: [0] pending, [1] running (state!=IDLE), [2] overrun.
//   W1C on bits [0],[2].
//  Reads: in_port <= mux(port_id) every cycle (1-cycle latency, no read side
//   effects). Unmapped addresses read 8'h00.
//  Reset: all regs 0, timer_conf=16'h0000, state IDLE; in_port, interrupt, tmr_go,
//   tmr_en, tmr_auto_load, prescaler_conf all 0.
//  Outputs tmr_en/tmr_auto_load/prescaler_conf are direct CTRL register bits.
//  FSM (tmr_go = state==ARMED):
//   IDLE : CTRL write with out_port[1]=1 and out_port[0]=1 -> ARMED next cycle.
//          A go write with en=0 is ignored.
//   ARMED: go_clear -> RUN (tmr_go drops the same edge).
//          en cleared -> IDLE.
//   RUN  : tmr_int: set pending; then auto_load=1 -> stay RUN,
//          auto_load=0 -> IDLE. en cleared -> IDLE.
//   A go write in ARMED/RUN is ignored. en-clear has priority over go_clear/tmr_int
//   state moves; tmr_int still sets pending.
//  Pending/overrun:
//   - tmr_int with pending=1 and no clear in the same cycle -> overrun<=1.
//   - Clear sources: interrupt_ack, STATUS W1C bit0.
//   - Set and clear in the same cycle: set wins, pending stays 1, no overrun.
//   - overrun is cleared only by W1C bit2.
//  interrupt <= pending & int_en (registered, 1 cycle after pending).
//   Deasserts the cycle after ack clears pending.
//  tmr_int is ignored while state==IDLE (stale pulse).
//  rst mid-operation returns everything to reset values at the next edge.
// TESTING
//  1 Reset: rst high 2 cycles -> all outputs 0, STATUS reads 8'h00.
//  2 Load staging: write +1=8'hF0, +2=8'hFF
//     -> timer_conf stays 16'h0000 until the +2 write, then 16'hFFF0.
//  3 One-shot: CTRL=8'h43 -> tmr_go=1 next cycle; go_clear pulse -> tmr_go=0,
//     STATUS=8'h02; tmr_int -> STATUS=8'h01, interrupt=1; interrupt_ack
//     -> interrupt=0 next cycle.
//  4 Auto-load: CTRL=8'h47, two tmr_int without ack
//     -> state RUN, STATUS=8'h07; write STATUS=8'h05 -> 8'h02.
//  5 Simultaneous: tmr_int and interrupt_ack same cycle with pending=1
//     -> pending stays 1, overrun stays 0.
//  6 Abort: CTRL=8'h03, then CTRL=8'h00 before go_clear
//     -> tmr_go=0, state IDLE; late tmr_int -> pending stays 0.

Source files
------------

// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
//   PicoBlaze-side controller for one timer instance. Decodes the processor
//   port bus into CTRL / LOAD_L / LOAD_H / STATUS registers, drives the
//   timer's configuration inputs, sequences the timer IDLE -> ARMED -> RUN,
//   and latches timer rolloffs into a pending flag that drives the processor
//   interrupt / acknowledge handshake.
//
//   Register map (offsets from BASE_ADDR):
//     +0 CTRL   RW  [0] en, [1] go (write-only, reads 0), [2] auto_load,
//                   [5:3] prescaler, [6] int_en, [7] reserved (reads 0)
//     +1 LOAD_L W   low byte staged into a shadow register
//     +2 LOAD_H W   timer_conf <= {out_port, shadow}
//     +3 STATUS RW  [0] pending, [1] running, [2] overrun; W1C on [0],[2]
//
//   Handshakes:
//     tmr_go is a level held while ARMED; the timer answers with a
//     one-cycle go_clear, which moves the FSM to RUN and drops tmr_go on the
//     same edge. interrupt is held until a one-cycle interrupt_ack clears
//     pending; it falls on the cycle after pending falls.
//
// Ports:
//   clk_in          in   system clock
//   rst             in   synchronous active-high reset
//   port_id[7:0]    in   PicoBlaze port address
//   write_strobe    in   one-cycle write qualifier
//   out_port[7:0]   in   write data
//   in_port[7:0]    out  registered read data (1-cycle latency)
//   interrupt       out  interrupt request to PicoBlaze
//   interrupt_ack   in   one-cycle acknowledge from PicoBlaze
//   prescaler_conf  out  timer prescaler select
//   timer_conf      out  timer reload value
//   tmr_en          out  timer enable
//   tmr_go          out  timer start request (held while ARMED)
//   tmr_auto_load   out  timer auto-reload enable
//   tmr_int         in   timer rolloff pulse
//   go_clear        in   timer accepted go
//   state_dbg[1:0]  out  FSM state (0 IDLE, 1 ARMED, 2 RUN)
// ----------------------------------------------------------------------------
module timer_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  port_id,
    input  logic        write_strobe,
    input  logic [7:0]  out_port,
    output logic [7:0]  in_port,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [2:0]  prescaler_conf,
    output logic [15:0] timer_conf,
    output logic        tmr_en,
    output logic        tmr_go,
    output logic        tmr_auto_load,
    input  logic        tmr_int,
    input  logic        go_clear,
    output logic [1:0]  state_dbg
);

    localparam logic [7:0] ADDR_CTRL   = BASE_ADDR;
    localparam logic [7:0] ADDR_LOAD_L = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_LOAD_H = BASE_ADDR + 8'd2;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + 8'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        en_q, auto_load_q, int_en_q;
    logic [2:0]  prescaler_q;
    logic [7:0]  shadow_q;
    logic        pending_q, overrun_q;

    logic        wr_ctrl, wr_load_l, wr_load_h, wr_status;
    logic        en_clear;
    logic        int_set, int_clr;
    logic [7:0]  rd_data;

    assign wr_ctrl   = write_strobe && (port_id == ADDR_CTRL);
    assign wr_load_l = write_strobe && (port_id == ADDR_LOAD_L);
    assign wr_load_h = write_strobe && (port_id == ADDR_LOAD_H);
    assign wr_status = write_strobe && (port_id == ADDR_STATUS);

    // Clearing en is recognised at the write itself so the FSM leaves
    // ARMED/RUN on the same edge the en bit drops.
    assign en_clear = wr_ctrl && !out_port[0];

    // Rolloff pulses seen while IDLE are stale and dropped.
    assign int_set = tmr_int && (state != IDLE);
    assign int_clr = interrupt_ack || (wr_status && out_port[0]);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_ctrl && out_port[1] && out_port[0])
                    state_next = ARMED;
            end
            ARMED: begin
                if (en_clear)
                    state_next = IDLE;
                else if (go_clear)
                    state_next = RUN;
            end
            RUN: begin
                if (en_clear)
                    state_next = IDLE;
                else if (tmr_int && !auto_load_q)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Configuration registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            en_q        <= 1'b0;
            auto_load_q <= 1'b0;
            prescaler_q <= 3'd0;
            int_en_q    <= 1'b0;
            shadow_q    <= 8'h00;
            timer_conf  <= 16'h0000;
        end else begin
            if (wr_ctrl) begin
                en_q        <= out_port[0];
                auto_load_q <= out_port[2];
                prescaler_q <= out_port[5:3];
                int_en_q    <= out_port[6];
            end
            if (wr_load_l)
                shadow_q <= out_port;
            if (wr_load_h)
                timer_conf <= {out_port, shadow_q};
        end
    end

    // Pending / overrun: a set in the same cycle as a clear wins and is not
    // counted as an overrun.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (int_set)
                pending_q <= 1'b1;
            else if (int_clr)
                pending_q <= 1'b0;

            if (int_set && pending_q && !int_clr)
                overrun_q <= 1'b1;
            else if (wr_status && out_port[2])
                overrun_q <= 1'b0;

            interrupt <= pending_q && int_en_q;
        end
    end

    // Read mux, registered into in_port; reads have no side effects.
    always_comb begin
        rd_data = 8'h00;
        case (port_id)
            ADDR_CTRL:   rd_data = {1'b0, int_en_q, prescaler_q, auto_load_q, 1'b0, en_q};
            ADDR_STATUS: rd_data = {5'b0, overrun_q, (state != IDLE), pending_q};
            default:     rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst)
            in_port <= 8'h00;
        else
            in_port <= rd_data;
    end

    assign tmr_en         = en_q;
    assign tmr_auto_load  = auto_load_q;
    assign prescaler_conf = prescaler_q;
    assign tmr_go         = (state == ARMED);
    assign state_dbg      = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed bench for timer_ctrl. A behavioural model tracks the register
//   file and timer sequencing from the register-map rules; a compare process
//   checks every DUT output against it on each falling edge, and directed
//   sequences pin the model with hand-computed literal values.
//   Inputs change 2 time units after the rising edge; tasks are entered and
//   left at that point.
// ----------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam logic [7:0] BASE = 8'h10;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [7:0]  port_id = 8'h00;
  logic        write_strobe = 1'b0;
  logic [7:0]  out_port = 8'h00;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic [2:0]  prescaler_conf;
  logic [15:0] timer_conf;
  logic        tmr_en;
  logic        tmr_go;
  logic        tmr_auto_load;
  logic        tmr_int = 1'b0;
  logic        go_clear = 1'b0;
  logic [1:0]  state_dbg;

  timer_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk_in(clk_in), .rst(rst), .port_id(port_id), .write_strobe(write_strobe),
    .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .prescaler_conf(prescaler_conf),
    .timer_conf(timer_conf), .tmr_en(tmr_en), .tmr_go(tmr_go),
    .tmr_auto_load(tmr_auto_load), .tmr_int(tmr_int), .go_clear(go_clear),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en, m_al, m_ie, m_armed, m_running, m_pend, m_ovr, m_irq;
  logic [2:0]  m_ps;
  logic [7:0]  m_shadow, m_in;
  logic [15:0] m_conf;
  bit          started = 0;

  always @(posedge clk_in) begin
    bit wr_c, wr_l, wr_h, wr_s, busy, set, clr;
    started = 1;
    if (rst) begin
      {m_en, m_al, m_ie, m_armed, m_running, m_pend, m_ovr, m_irq} = '0;
      m_ps = '0; m_shadow = '0; m_in = '0; m_conf = '0;
    end else begin
      wr_c = write_strobe && port_id == BASE;
      wr_l = write_strobe && port_id == BASE + 8'd1;
      wr_h = write_strobe && port_id == BASE + 8'd2;
      wr_s = write_strobe && port_id == BASE + 8'd3;
      busy = m_armed || m_running;
      // read value from the pre-edge register contents
      if (port_id == BASE)
        m_in = {1'b0, m_ie, m_ps, m_al, 1'b0, m_en};
      else if (port_id == BASE + 8'd3)
        m_in = {5'b0, m_ovr, busy, m_pend};
      else
        m_in = 8'h00;
      m_irq = m_pend && m_ie;
      set = tmr_int && busy;
      clr = interrupt_ack || (wr_s && out_port[0]);
      if (set && m_pend && !clr) m_ovr = 1;
      else if (wr_s && out_port[2]) m_ovr = 0;
      if (set) m_pend = 1;
      else if (clr) m_pend = 0;
      // sequencing: go needs en in the same write; dropping en aborts
      if (!busy) begin
        if (wr_c && out_port[1] && out_port[0]) m_armed = 1;
      end else if (wr_c && !out_port[0]) begin
        m_armed = 0; m_running = 0;
      end else if (m_armed) begin
        if (go_clear) begin m_armed = 0; m_running = 1; end
      end else if (tmr_int && !m_al) begin
        m_running = 0;
      end
      if (wr_c) begin
        m_en = out_port[0]; m_al = out_port[2]; m_ps = out_port[5:3]; m_ie = out_port[6];
      end
      if (wr_h) m_conf = {out_port, m_shadow};
      if (wr_l) m_shadow = out_port;
    end
  end

  // compare process
  always @(negedge clk_in) begin
    if (started) begin
      chk("in_port", {8'h0, in_port}, {8'h0, m_in});
      chk("interrupt", {15'h0, interrupt}, {15'h0, m_irq});
      chk("prescaler_conf", {13'h0, prescaler_conf}, {13'h0, m_ps});
      chk("timer_conf", timer_conf, m_conf);
      chk("tmr_en", {15'h0, tmr_en}, {15'h0, m_en});
      chk("tmr_go", {15'h0, tmr_go}, {15'h0, m_armed});
      chk("tmr_auto_load", {15'h0, tmr_auto_load}, {15'h0, m_al});
      chk("state_dbg", {14'h0, state_dbg}, m_running ? 16'd2 : (m_armed ? 16'd1 : 16'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in); #2;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
    port_id = addr;
    step();
    chk(name, {8'h0, in_port}, {8'h0, exp});
  endtask

  task automatic pulse_go_clear();
    go_clear = 1'b1; step(); go_clear = 1'b0;
  endtask

  task automatic pulse_int();
    tmr_int = 1'b1; step(); tmr_int = 1'b0;
  endtask

  task automatic pulse_ack();
    interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    // 1 reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("rst_tmr_go", {15'h0, tmr_go}, 16'h0);
    chk("rst_interrupt", {15'h0, interrupt}, 16'h0);
    chk("rst_timer_conf", timer_conf, 16'h0000);
    rd_chk("rst_status", BASE + 8'd3, 8'h00);

    // 2 load staging
    wr(BASE + 8'd1, 8'hF0);
    chk("load_l_only", timer_conf, 16'h0000);
    wr(BASE + 8'd2, 8'hFF);
    chk("load_h", timer_conf, 16'hFFF0);

    // go with en=0 is ignored
    wr(BASE, 8'h02);
    chk("go_no_en", {15'h0, tmr_go}, 16'h0);

    // CTRL readback: go and reserved bits read 0
    wr(BASE, 8'h39);
    chk("presc", {13'h0, prescaler_conf}, 16'h7);
    rd_chk("ctrl_rd", BASE, 8'h39);
    wr(BASE, 8'h00);

    // 3 one-shot
    wr(BASE, 8'h43);
    chk("oneshot_go", {15'h0, tmr_go}, 16'h1);
    pulse_go_clear();
    chk("oneshot_go_drop", {15'h0, tmr_go}, 16'h0);
    rd_chk("oneshot_run", BASE + 8'd3, 8'h02);
    pulse_int();
    rd_chk("oneshot_pend", BASE + 8'd3, 8'h01);
    chk("oneshot_irq", {15'h0, interrupt}, 16'h1);
    pulse_ack();
    step();
    chk("oneshot_irq_drop", {15'h0, interrupt}, 16'h0);

    // 4 auto-load with overrun
    wr(BASE, 8'h47);
    pulse_go_clear();
    pulse_int();
    step();
    pulse_int();
    rd_chk("auto_status", BASE + 8'd3, 8'h07);
    chk("auto_state", {14'h0, state_dbg}, 16'd2);
    wr(BASE + 8'd3, 8'h05);
    rd_chk("auto_w1c", BASE + 8'd3, 8'h02);

    // 5 simultaneous set and ack
    pulse_int();
    tmr_int = 1'b1; interrupt_ack = 1'b1; step();
    tmr_int = 1'b0; interrupt_ack = 1'b0;
    rd_chk("simul_status", BASE + 8'd3, 8'h03);

    // 6 abort before go_clear, late rolloff ignored
    wr(BASE, 8'h00);
    wr(BASE + 8'd3, 8'h05);
    wr(BASE, 8'h03);
    chk("abort_go", {15'h0, tmr_go}, 16'h1);
    wr(BASE, 8'h00);
    chk("abort_go_drop", {15'h0, tmr_go}, 16'h0);
    chk("abort_state", {14'h0, state_dbg}, 16'd0);
    pulse_int();
    rd_chk("abort_status", BASE + 8'd3, 8'h00);

    // unmapped / write-only addresses read 0
    rd_chk("unmapped", 8'h20, 8'h00);
    rd_chk("load_rd", BASE + 8'd2, 8'h00);

    // all-ones CTRL then reset mid-operation
    wr(BASE, 8'hFF);
    rd_chk("ctrl_ff", BASE, 8'h7D);
    chk("ff_go", {15'h0, tmr_go}, 16'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_go", {15'h0, tmr_go}, 16'h0);
    chk("mid_rst_en", {15'h0, tmr_en}, 16'h0);
    chk("mid_rst_conf", timer_conf, 16'h0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
